// File: rtl/storage_xbar_if.sv
// Bus bundle for storage_xbar_ctrl: core request/response port, SRAM macro pins
// and the pipelined flash-engine bus. slave = controller side, master = core/memory side.
interface storage_xbar_if #(
  parameter int MEM_W   = 32,
  parameter int SRAM_AW = 11,
  parameter int EXT_AW  = 22
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [31:0]        req_addr;
  logic [MEM_W-1:0]   req_wdata;
  logic [MEM_W/8-1:0] req_be;

  logic               rsp_valid;
  logic [MEM_W-1:0]   rsp_rdata;
  logic               rsp_err;

  logic               sram_cen;
  logic               sram_wen;
  logic [SRAM_AW-1:0] sram_a;
  logic [MEM_W-1:0]   sram_d;
  logic [MEM_W-1:0]   sram_q;

  logic               ext_cyc;
  logic               ext_stb;
  logic [EXT_AW-1:0]  ext_addr;
  logic               ext_stall;
  logic               ext_ack;
  logic [MEM_W-1:0]   ext_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output sram_cen, sram_wen, sram_a, sram_d,
    input  sram_q,
    output ext_cyc, ext_stb, ext_addr,
    input  ext_stall, ext_ack, ext_rdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  sram_cen, sram_wen, sram_a, sram_d,
    output sram_q,
    input  ext_cyc, ext_stb, ext_addr,
    output ext_stall, ext_ack, ext_rdata
  );
endinterface

// File: rtl/storage_xbar_ctrl.sv
// Storage controller: routes core accesses to on-chip SRAM (RMW for partial writes)
// or read-only SPI flash, with access timeout and an SPI programming-mode bypass.
module storage_xbar_ctrl #(
  parameter int MEM_W   = 32,
  parameter int SRAM_AW = 11,
  parameter int EXT_AW  = 22,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  storage_xbar_if.slave   bus,
  input  logic            prog_mode_req,
  output logic            prog_mode_active,
  input  logic            fl_spi_cs_n,
  input  logic            fl_spi_sck,
  input  logic            fl_spi_mosi,
  output logic            fl_spi_miso,
  input  logic            prog_spi_cs_n,
  input  logic            prog_spi_sck,
  input  logic            prog_spi_mosi,
  output logic            prog_spi_miso,
  output logic            ext_spi_cs_n,
  output logic            ext_spi_sck,
  output logic            ext_spi_mosi,
  input  logic            ext_spi_miso,
  output logic [2:0]      state_dbg
);

  localparam int BW  = MEM_W / 8;
  localparam int LSB = $clog2(BW);
  localparam int TW  = ($clog2(TIMEOUT + 1) > 11) ? $clog2(TIMEOUT + 1) : 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_ACC  = 3'd1,
    S_CAP  = 3'd2,
    S_WB   = 3'd3,
    X_REQ  = 3'd4,
    X_WAIT = 3'd5,
    PROG   = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic              we_q;
  logic [BW-1:0]     be_q;
  logic [MEM_W-1:0]  wdata_q;
  logic [EXT_AW-1:0] word_q;
  logic [TW-1:0]     tmo_cnt;

  logic              accept;
  logic              in_sram, in_flash, in_xfer, tmo_hit;
  logic              rsp_set, rsp_err_nxt, merge_set;
  logic [MEM_W-1:0]  rsp_data_nxt;

  function automatic logic [MEM_W-1:0] merge_bytes(input logic [MEM_W-1:0] old_w,
                                                    input logic [MEM_W-1:0] new_w,
                                                    input logic [BW-1:0]    be);
    merge_bytes = old_w;
    for (int i = 0; i < BW; i++)
      if (be[i]) merge_bytes[8*i +: 8] = new_w[8*i +: 8];
  endfunction

  // Request: a transfer happens on a clk edge where req_valid && req_ready.
  // Response: rsp_valid is a single-cycle pulse, no backpressure; rsp_* are 0 otherwise.
  assign bus.req_ready = (state == IDLE) && !prog_mode_req && rst;
  assign accept        = bus.req_valid && bus.req_ready;

  assign in_sram  = (bus.req_addr[31:SRAM_AW+LSB] == '0);
  assign in_flash = (bus.req_addr[31:EXT_AW+LSB] == '0);
  assign in_xfer  = (state == X_REQ) || (state == X_WAIT);
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));

  assign bus.sram_a   = word_q[SRAM_AW-1:0];
  assign bus.sram_d   = wdata_q;
  assign bus.ext_addr = word_q;

  assign prog_mode_active = (state == PROG);
  assign state_dbg        = state;

  // SPI routing follows the registered state only.
  assign ext_spi_cs_n  = prog_mode_active ? prog_spi_cs_n : fl_spi_cs_n;
  assign ext_spi_sck   = prog_mode_active ? prog_spi_sck  : fl_spi_sck;
  assign ext_spi_mosi  = prog_mode_active ? prog_spi_mosi : fl_spi_mosi;
  assign fl_spi_miso   = prog_mode_active ? 1'b1 : ext_spi_miso;
  assign prog_spi_miso = prog_mode_active ? ext_spi_miso : 1'b0;

  always_comb begin
    state_nxt    = state;
    rsp_set      = 1'b0;
    rsp_err_nxt  = 1'b0;
    rsp_data_nxt = '0;
    merge_set    = 1'b0;
    bus.sram_cen = 1'b1;
    bus.sram_wen = 1'b1;
    bus.ext_cyc  = 1'b0;
    bus.ext_stb  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_sram) begin
            if (bus.req_we && (bus.req_be == '0)) rsp_set = 1'b1;
            else                                  state_nxt = S_ACC;
          end else if (!bus.req_we && in_flash) begin
            state_nxt = X_REQ;
          end else begin
            rsp_set     = 1'b1;
            rsp_err_nxt = 1'b1;
          end
        end else if (prog_mode_req) begin
          state_nxt = PROG;
        end
      end
      S_ACC: begin
        bus.sram_cen = 1'b0;
        if (we_q && (&be_q)) begin
          bus.sram_wen = 1'b0;
          rsp_set      = 1'b1;
          state_nxt    = IDLE;
        end else begin
          state_nxt = S_CAP;
        end
      end
      S_CAP: begin
        if (we_q) begin
          merge_set = 1'b1;
          state_nxt = S_WB;
        end else begin
          rsp_set      = 1'b1;
          rsp_data_nxt = bus.sram_q;
          state_nxt    = IDLE;
        end
      end
      S_WB: begin
        bus.sram_cen = 1'b0;
        bus.sram_wen = 1'b0;
        rsp_set      = 1'b1;
        state_nxt    = IDLE;
      end
      X_REQ: begin
        bus.ext_cyc = 1'b1;
        bus.ext_stb = 1'b1;
        // An ack alongside the accepted strobe completes the access at once.
        if (!bus.ext_stall && bus.ext_ack) begin
          rsp_set      = 1'b1;
          rsp_data_nxt = bus.ext_rdata;
          state_nxt    = IDLE;
        end else if (tmo_hit) begin
          rsp_set     = 1'b1;
          rsp_err_nxt = 1'b1;
          state_nxt   = IDLE;
        end else if (!bus.ext_stall) begin
          state_nxt = X_WAIT;
        end
      end
      X_WAIT: begin
        bus.ext_cyc = 1'b1;
        if (bus.ext_ack) begin
          rsp_set      = 1'b1;
          rsp_data_nxt = bus.ext_rdata;
          state_nxt    = IDLE;
        end else if (tmo_hit) begin
          rsp_set     = 1'b1;
          rsp_err_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      PROG: begin
        if (!prog_mode_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      word_q        <= '0;
      tmo_cnt       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.rsp_valid <= rsp_set;
      bus.rsp_rdata <= rsp_data_nxt;
      bus.rsp_err   <= rsp_err_nxt;
      if (accept) begin
        we_q    <= bus.req_we;
        be_q    <= bus.req_be;
        wdata_q <= bus.req_wdata;
        word_q  <= bus.req_addr[LSB +: EXT_AW];
      end else if (merge_set) begin
        wdata_q <= merge_bytes(bus.sram_q, wdata_q, be_q);
      end
      if (in_xfer && (state_nxt != IDLE)) tmo_cnt <= tmo_cnt + 1'b1;
      else                                tmo_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_storage_xbar_ctrl.sv
// Directed bench for storage_xbar_ctrl: SRAM read/write/RMW, flash reads with stall,
// timeout, decode errors, programming-mode SPI bypass and mid-access reset.
module tb_storage_xbar_ctrl;

  logic clk;
  logic rst;
  logic prog_mode_req, prog_mode_active;
  logic fl_spi_cs_n, fl_spi_sck, fl_spi_mosi, fl_spi_miso;
  logic prog_spi_cs_n, prog_spi_sck, prog_spi_mosi, prog_spi_miso;
  logic ext_spi_cs_n, ext_spi_sck, ext_spi_mosi, ext_spi_miso;
  logic [2:0] state_dbg;

  int n_chk  = 0;
  int n_pass = 0;
  int n_rd   = 0;
  int n_wr   = 0;
  int n_cyc  = 0;
  int n_rsp  = 0;
  int lat;
  int rsp_before;

  logic [31:0] sram_mem [0:2047];

  storage_xbar_if #(.MEM_W(32), .SRAM_AW(11), .EXT_AW(22)) bus ();

  storage_xbar_ctrl #(.MEM_W(32), .SRAM_AW(11), .EXT_AW(22), .TIMEOUT(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .prog_mode_req    (prog_mode_req),
    .prog_mode_active (prog_mode_active),
    .fl_spi_cs_n      (fl_spi_cs_n),
    .fl_spi_sck       (fl_spi_sck),
    .fl_spi_mosi      (fl_spi_mosi),
    .fl_spi_miso      (fl_spi_miso),
    .prog_spi_cs_n    (prog_spi_cs_n),
    .prog_spi_sck     (prog_spi_sck),
    .prog_spi_mosi    (prog_spi_mosi),
    .prog_spi_miso    (prog_spi_miso),
    .ext_spi_cs_n     (ext_spi_cs_n),
    .ext_spi_sck      (ext_spi_sck),
    .ext_spi_mosi     (ext_spi_mosi),
    .ext_spi_miso     (ext_spi_miso),
    .state_dbg        (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SRAM macro model and activity monitor
  always @(posedge clk) begin
    if (!bus.sram_cen) begin
      if (!bus.sram_wen) begin
        sram_mem[bus.sram_a] <= bus.sram_d;
        n_wr <= n_wr + 1;
      end else begin
        bus.sram_q <= sram_mem[bus.sram_a];
        n_rd <= n_rd + 1;
      end
    end
    if (bus.ext_cyc)   n_cyc <= n_cyc + 1;
    if (bus.rsp_valid) n_rsp <= n_rsp + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Returns cycles from the accept edge to the response cycle, or -1 on expiry.
  task automatic wait_rsp(output int l);
    l = 1;
    while (!bus.rsp_valid && l < 60) begin
      tick();
      l++;
    end
    if (!bus.rsp_valid) l = -1;
  endtask

  initial begin
    rst = 1'b0;
    prog_mode_req = 1'b0;
    fl_spi_cs_n = 1'b1; fl_spi_sck = 1'b0; fl_spi_mosi = 1'b0;
    prog_spi_cs_n = 1'b1; prog_spi_sck = 1'b0; prog_spi_mosi = 1'b0;
    ext_spi_miso = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0;
    bus.ext_stall = 1'b0; bus.ext_ack = 1'b0; bus.ext_rdata = '0;
    bus.sram_q = '0;

    // Reset values
    tick(); tick(); tick();
    check("rst_ready",  bus.req_ready, 0);
    check("rst_rsp",    bus.rsp_valid, 0);
    check("rst_cen",    bus.sram_cen, 1);
    check("rst_wen",    bus.sram_wen, 1);
    check("rst_cyc",    bus.ext_cyc, 0);
    check("rst_prog",   prog_mode_active, 0);
    check("rst_state",  state_dbg, 0);
    rst = 1'b1;
    #1;
    check("ready_out_of_rst", bus.req_ready, 1);

    // SRAM full-word write then read back
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(lat);
    check("wr_lat",   lat, 2);
    check("wr_err",   bus.rsp_err, 0);
    check("wr_rdata", bus.rsp_rdata, 0);
    tick();
    check("rsp_one_cycle", bus.rsp_valid, 0);
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    wait_rsp(lat);
    check("rd_lat",   lat, 3);
    check("rd_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    check("rd_err",   bus.rsp_err, 0);

    // Partial write: byte 1 replaced by 0xAA
    tick();
    n_rd = 0; n_wr = 0;
    issue(1'b1, 32'h0000_0010, 32'h0000_AA00, 4'b0010);
    wait_rsp(lat);
    check("pw_lat",    lat, 4);
    check("pw_rd_cnt", n_rd, 1);
    check("pw_wr_cnt", n_wr, 1);
    check("pw_err",    bus.rsp_err, 0);

    // be==0 write touches nothing
    tick();
    n_rd = 0; n_wr = 0;
    issue(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0);
    wait_rsp(lat);
    check("be0_lat",  lat, 1);
    check("be0_strb", n_rd + n_wr, 0);
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    wait_rsp(lat);
    check("pw_readback", bus.rsp_rdata, 32'hDEAD_AAEF);

    // Flash read with stall and delayed ack
    tick();
    bus.ext_stall = 1'b1;
    issue(1'b0, 32'h0000_4000, 32'h0, 4'hF);
    check("fl_cyc",  bus.ext_cyc, 1);
    check("fl_stb",  bus.ext_stb, 1);
    check("fl_addr", bus.ext_addr, 22'h001000);
    tick(); tick();
    check("fl_stb_stalled", bus.ext_stb, 1);
    tick();
    bus.ext_stall = 1'b0;
    tick();
    check("fl_stb_drop", bus.ext_stb, 0);
    check("fl_cyc_hold", bus.ext_cyc, 1);
    tick();
    bus.ext_ack = 1'b1; bus.ext_rdata = 32'h1357_9BDF;
    tick();
    bus.ext_ack = 1'b0;
    check("fl_rsp",   bus.rsp_valid, 1);
    check("fl_rdata", bus.rsp_rdata, 32'h1357_9BDF);
    check("fl_err",   bus.rsp_err, 0);
    check("fl_cyc_after", bus.ext_cyc, 0);

    // Flash read acked with the accepted strobe
    issue(1'b0, 32'h0000_4004, 32'h0, 4'hF);
    check("fa_addr", bus.ext_addr, 22'h001001);
    bus.ext_ack = 1'b1; bus.ext_rdata = 32'h0BAD_F00D;
    tick();
    bus.ext_ack = 1'b0;
    check("fa_rsp",   bus.rsp_valid, 1);
    check("fa_rdata", bus.rsp_rdata, 32'h0BAD_F00D);

    // Timeout with no ack, then a late ack is ignored
    tick();
    issue(1'b0, 32'h0000_8000, 32'h0, 4'hF);
    wait_rsp(lat);
    check("to_lat",   lat, 17);
    check("to_err",   bus.rsp_err, 1);
    check("to_rdata", bus.rsp_rdata, 0);
    check("to_cyc",   bus.ext_cyc, 0);
    bus.ext_ack = 1'b1; bus.ext_rdata = 32'h5555_5555;
    tick();
    bus.ext_ack = 1'b0;
    check("late_ack_rsp",   bus.rsp_valid, 0);
    check("late_ack_state", state_dbg, 0);

    // Decode errors
    n_rd = 0; n_wr = 0; n_cyc = 0;
    issue(1'b1, 32'h0000_4000, 32'h1234_5678, 4'hF);
    wait_rsp(lat);
    check("wfl_lat",   lat, 1);
    check("wfl_err",   bus.rsp_err, 1);
    check("wfl_rdata", bus.rsp_rdata, 0);
    issue(1'b0, 32'h0100_0000, 32'h0, 4'hF);
    wait_rsp(lat);
    check("oor_lat", lat, 1);
    check("oor_err", bus.rsp_err, 1);
    tick();
    check("err_no_cyc",  n_cyc, 0);
    check("err_no_sram", n_rd + n_wr, 0);

    // Programming mode requested during a flash wait
    issue(1'b0, 32'h0000_4000, 32'h0, 4'hF);
    prog_mode_req = 1'b1;
    tick(); tick();
    check("pm_wait_inactive", prog_mode_active, 0);
    check("pm_wait_cyc",      bus.ext_cyc, 1);
    bus.ext_ack = 1'b1; bus.ext_rdata = 32'h2468_ACE0;
    tick();
    bus.ext_ack = 1'b0;
    check("pm_rsp",   bus.rsp_valid, 1);
    check("pm_rdata", bus.rsp_rdata, 32'h2468_ACE0);
    tick();
    check("pm_active", prog_mode_active, 1);
    check("pm_ready",  bus.req_ready, 0);
    check("pm_cyc",    bus.ext_cyc, 0);
    prog_spi_sck = 1'b1; fl_spi_sck = 1'b0; #1;
    check("pm_sck_hi", ext_spi_sck, 1);
    prog_spi_sck = 1'b0; fl_spi_sck = 1'b1; #1;
    check("pm_sck_lo", ext_spi_sck, 0);
    ext_spi_miso = 1'b1; #1;
    check("pm_prog_miso", prog_spi_miso, 1);
    check("pm_fl_miso",   fl_spi_miso, 1);
    prog_mode_req = 1'b0;
    tick();
    check("pm_exit",       prog_mode_active, 0);
    check("pm_exit_ready", bus.req_ready, 1);
    check("fl_sck_routed", ext_spi_sck, 1);
    ext_spi_miso = 1'b0; #1;
    check("fl_miso_routed", fl_spi_miso, 0);
    check("prog_miso_zero", prog_spi_miso, 0);

    // Reset in the middle of a flash read
    issue(1'b0, 32'h0000_4000, 32'h0, 4'hF);
    tick();
    rsp_before = n_rsp;
    rst = 1'b0;
    tick();
    check("mr_cyc",   bus.ext_cyc, 0);
    check("mr_rsp",   bus.rsp_valid, 0);
    check("mr_cen",   bus.sram_cen, 1);
    check("mr_ready", bus.req_ready, 0);
    check("mr_state", state_dbg, 0);
    tick(); tick();
    check("mr_no_rsp", n_rsp - rsp_before, 0);
    rst = 1'b1;
    tick();
    check("mr_ready_after", bus.req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
